// File: rtl/router_pkt_fifo.sv
// Purpose: packet-aware byte FIFO for the router. Entries carry a start-of-packet tag and
//          the read side tracks packet length so it can flag the last byte and any truncation.
// Latency: one cycle from an accepted read to data_out/data_valid. Backpressure: writes to a
//          full FIFO and reads from an empty one are dropped and reported as overflow/underflow.
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LEN_LSB  = 2,
    parameter int LEN_MSB  = 7,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        soft_reset,
    input  logic                        write_enb,
    input  logic                        read_enb,
    input  logic                        lfd_state,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    output logic                        data_valid,
    output logic                        sop_out,
    output logic                        eop_out,
    output logic                        pkt_active,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        pkt_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [LEN_W:0]  REM_ONE = (LEN_W+1)'(1);
    localparam logic [ADDR_W:0] AF_THR  = (ADDR_W+1)'(AF_LEVEL);

    // Storage: {sop, data}; contents are never cleared, pointers alone decide what is readable.
    logic [DATA_W:0]     r_mem [DEPTH];

    logic [ADDR_W:0]     r_wp;
    logic [ADDR_W:0]     r_rp;
    logic                r_sop_q;
    logic [LEN_W:0]      r_rem;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dv;
    logic                r_sop;
    logic                r_eop;
    logic                r_err;
    logic                r_ovf;
    logic                r_udf;

    logic                w_empty;
    logic                w_full;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [DATA_W:0]     w_rd_entry;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W:0]     w_occ;

    // Status comes straight from the pre-edge pointers, so a simultaneous read and write
    // is judged against the state before either takes effect.
    assign w_empty    = (r_wp == r_rp);
    assign w_full     = (r_wp[ADDR_W-1:0] == r_rp[ADDR_W-1:0]) && (r_wp[ADDR_W] != r_rp[ADDR_W]);
    assign w_occ      = r_wp - r_rp;
    assign w_wr_acc   = resetn && !soft_reset && write_enb && !w_full;
    assign w_rd_acc   = read_enb && !w_empty;
    assign w_rd_entry = r_mem[r_rp[ADDR_W-1:0]];
    assign w_len      = w_rd_entry[LEN_MSB:LEN_LSB];

    // Entry write; the sop tag is the lfd_state seen one cycle earlier.
    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wp[ADDR_W-1:0]] <= {r_sop_q, data_in};
        end
    end

    // Pointers, read data, packet-length tracking and event pulses; hard reset and flush clear alike.
    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_sop_q <= 1'b0;
            r_rem   <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_sop_q <= lfd_state;
            r_ovf   <= write_enb && w_full;
            r_udf   <= read_enb && w_empty;
            r_dv    <= w_rd_acc;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_err   <= 1'b0;
            if (w_wr_acc) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rp   <= r_rp + PTR_ONE;
                r_dout <= w_rd_entry[DATA_W-1:0];
                if (w_rd_entry[DATA_W]) begin
                    // Header: a still-running packet means the previous one was truncated.
                    r_sop <= 1'b1;
                    r_err <= (r_rem != '0);
                    r_rem <= {1'b0, w_len} + REM_ONE;
                end else if (r_rem != '0) begin
                    r_rem <= r_rem - REM_ONE;
                    r_eop <= (r_rem == REM_ONE);
                end else begin
                    // Byte outside any packet: passed through, flagged.
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign data_out    = r_dout;
    assign data_valid  = r_dv;
    assign sop_out     = r_sop;
    assign eop_out     = r_eop;
    assign pkt_err     = r_err;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
    assign pkt_active  = (r_rem != '0);
    assign full        = w_full;
    assign empty       = w_empty;
    assign occupancy   = w_occ;
    assign almost_full = (w_occ >= AF_THR);

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: directed packet scenarios plus random traffic,
// checked against a queue-based packet model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_router_pkt_fifo;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       read_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_valid, sop_out, eop_out, pkt_active;
    logic       full, empty, almost_full, overflow, underflow, pkt_err;
    logic [4:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    router_pkt_fifo dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .sop_out(sop_out), .eop_out(eop_out), .pkt_active(pkt_active),
        .full(full), .empty(empty), .almost_full(almost_full),
        .occupancy(occupancy), .overflow(overflow), .underflow(underflow),
        .pkt_err(pkt_err)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of {sop,byte} entries plus a bytes-left-in-packet count.
    logic [8:0] mq[$];
    logic       m_sopq = 1'b0;
    int         m_rem  = 0;
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0, m_sop = 1'b0, m_eop = 1'b0, m_err = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    task automatic model_edge(input logic rn, input logic sr, input logic we, input logic re,
                              input logic lfd, input logic [7:0] din);
        logic [8:0] e;
        bit         f, em;
        if (!rn || sr) begin
            mq.delete();
            m_sopq = 1'b0; m_rem = 0; m_dout = 8'h00;
            m_dv = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            f  = (mq.size() == 16);
            em = (mq.size() == 0);
            m_ovf = we && f;
            m_udf = re && em;
            m_dv  = re && !em;
            m_sop = 1'b0; m_eop = 1'b0; m_err = 1'b0;
            if (re && !em) begin
                e = mq.pop_front();
                m_dout = e[7:0];
                if (e[8]) begin
                    m_sop = 1'b1;
                    m_err = (m_rem != 0);
                    m_rem = int'(e[7:2]) + 1;
                end else if (m_rem > 0) begin
                    m_rem = m_rem - 1;
                    m_eop = (m_rem == 0);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (we && !f) mq.push_back({m_sopq, din});
            m_sopq = lfd;
        end
    endtask

    function automatic logic [22:0] exp_vec();
        return {m_dout, m_dv, m_sop, m_eop, m_err, m_ovf, m_udf,
                mq.size() == 16, mq.size() == 0, mq.size() >= 14, m_rem != 0, 5'(mq.size())};
    endfunction

    function automatic logic [22:0] obs_vec();
        return {data_out, data_valid, sop_out, eop_out, pkt_err, overflow, underflow,
                full, empty, almost_full, pkt_active, occupancy};
    endfunction

    // One clock: present inputs, advance the model at the edge, settle, release inputs.
    task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] din,
                       input logic sr);
        write_enb = we; read_enb = re; lfd_state = lfd; data_in = din; soft_reset = sr;
        @(posedge clock);
        model_edge(resetn, sr, we, re, lfd, din);
        #1;
        write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; soft_reset = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0);
        cyc(1'b0, 1'b0, 0, 8'h00, 1'b0);
        resetn = 1'b1;
        n_tests++; if ({empty, full, occupancy, pkt_active, data_valid, data_out} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL reset_state: got %h want %h", {empty, full, occupancy, pkt_active, data_valid, data_out}, {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}); end
        n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_packet();
        logic [7:0] b[4];
        logic [7:0] want;
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h0C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            cyc(1'b1, 1'b0, 1'b0, b[i], 1'b0);
        end
        n_tests++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL pkt_occ_after_write: got %0d want 5", occupancy); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            want = (i == 0) ? 8'h0C : b[i-1];
            n_tests++; if ({data_valid, sop_out, eop_out, pkt_err, data_out} !== {1'b1, i == 0, i == 4, 1'b0, want}) begin n_fail++; $display("FAIL pkt_read%0d: got %h want %h", i, {data_valid, sop_out, eop_out, pkt_err, data_out}, {1'b1, i == 0, i == 4, 1'b0, want}); end
        end
        n_tests++; if ({occupancy, empty, pkt_active} !== {5'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL pkt_drained: got %h want %h", {occupancy, empty, pkt_active}, {5'd0, 1'b1, 1'b0}); end
    endtask

    task automatic test_full_overflow();
        logic [7:0] d[16];
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'($urandom);
            cyc(1'b1, 1'b0, 1'b0, d[i], 1'b0);
            n_tests++; if ({almost_full, full} !== {i >= 13, i == 15}) begin n_fail++; $display("FAIL fill_flags occ=%0d: got %b want %b", i + 1, {almost_full, full}, {i >= 13, i == 15}); end
        end
        cyc(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        n_tests++; if ({overflow, occupancy, full} !== {1'b1, 5'd16, 1'b1}) begin n_fail++; $display("FAIL overflow: got %h want %h", {overflow, occupancy, full}, {1'b1, 5'd16, 1'b1}); end
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_pulse: got %b want 0", overflow); end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            n_tests++; if ({data_valid, data_out} !== {1'b1, d[i]}) begin n_fail++; $display("FAIL drain_order%0d: got %h want %h", i, {data_valid, data_out}, {1'b1, d[i]}); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        n_tests++; if ({occupancy, overflow, data_valid} !== {5'd15, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rw_at_full: got %h want %h", {occupancy, overflow, data_valid}, {5'd15, 1'b1, 1'b1}); end
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        n_tests++; if (occupancy !== 5'd5) begin n_fail++; $display("FAIL rw_at_5: got %0d want 5", occupancy); end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
            n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL stream%0d: got %h want %h", i, obs_vec(), exp_vec()); end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL stream_drain%0d: got %h want %h", i, obs_vec(), exp_vec()); end
        end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if ({underflow, data_valid, data_out} !== {1'b1, 1'b0, m_dout}) begin n_fail++; $display("FAIL underflow: got %h want %h", {underflow, data_valid, data_out}, {1'b1, 1'b0, m_dout}); end
        cyc(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
        n_tests++; if ({underflow, data_valid, occupancy} !== {1'b1, 1'b0, 5'd1}) begin n_fail++; $display("FAIL rw_at_empty: got %h want %h", {underflow, data_valid, occupancy}, {1'b1, 1'b0, 5'd1}); end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if ({data_valid, data_out, underflow} !== {1'b1, 8'h5A, 1'b0}) begin n_fail++; $display("FAIL read_after_empty_write: got %h want %h", {data_valid, data_out, underflow}, {1'b1, 8'h5A, 1'b0}); end
    endtask

    task automatic test_len0();
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h03, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h9C, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if ({sop_out, eop_out, pkt_err, pkt_active} !== 4'b1001) begin n_fail++; $display("FAIL len0_header: got %b want 1001", {sop_out, eop_out, pkt_err, pkt_active}); end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if ({sop_out, eop_out, pkt_err, pkt_active, data_out} !== {4'b0100, 8'h9C}) begin n_fail++; $display("FAIL len0_parity: got %h want %h", {sop_out, eop_out, pkt_err, pkt_active, data_out}, {4'b0100, 8'h9C}); end
    endtask

    task automatic test_truncated();
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h21, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h08, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            n_tests++; if ({pkt_err, pkt_active} !== 2'b01) begin n_fail++; $display("FAIL trunc_body%0d: got %b want 01", i, {pkt_err, pkt_active}); end
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if ({pkt_err, sop_out, pkt_active, data_out} !== {3'b111, 8'h08}) begin n_fail++; $display("FAIL trunc_err: got %h want %h", {pkt_err, sop_out, pkt_active, data_out}, {3'b111, 8'h08}); end
        n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL trunc_model: got %h want %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_soft_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        n_tests++; if ({occupancy, pkt_active} !== {5'd7, 1'b1}) begin n_fail++; $display("FAIL pre_flush: got %h want %h", {occupancy, pkt_active}, {5'd7, 1'b1}); end
        cyc(1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
        n_tests++; if ({empty, occupancy, pkt_active, data_out, data_valid} !== {1'b1, 5'd0, 1'b0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL flush: got %h want %h", {empty, occupancy, pkt_active, data_out, data_valid}, {1'b1, 5'd0, 1'b0, 8'h00, 1'b0}); end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        n_tests++; if ({underflow, data_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_no_stale: got %b want 10", {underflow, data_valid}); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h04, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h31, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h32, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            n_tests++; if ({sop_out, eop_out, pkt_err} !== {i == 0, i == 2, 1'b0}) begin n_fail++; $display("FAIL post_flush_pkt%0d: got %b want %b", i, {sop_out, eop_out, pkt_err}, {i == 0, i == 2, 1'b0}); end
        end
    endtask

    task automatic test_random();
        logic we, re, lfd, sr;
        for (int i = 0; i < 1500; i++) begin
            we  = ($urandom_range(0, 99) < 55);
            re  = ($urandom_range(0, 99) < 50);
            lfd = ($urandom_range(0, 99) < 12);
            sr  = ($urandom_range(0, 99) < 2);
            cyc(we, re, lfd, 8'($urandom), sr);
            n_tests++; if (obs_vec() !== exp_vec()) begin n_fail++; $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec()); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_packet();
        test_full_overflow();
        test_simultaneous();
        test_underflow();
        test_len0();
        test_truncated();
        test_soft_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
